// File: rtl/sram_arbiter_pkg.sv
// Shared types and defaults for the SRAM arbiter: FSM states, slot kinds and
// the location of the power-on scandoubler config byte.
package sram_arbiter_pkg;

   localparam logic [20:0] CFG_ADDR_DEF = 21'h008FD5;
   localparam int          CFG_WAIT_DEF = 7;

   typedef enum logic [1:0] {
      ST_CFG_WAIT   = 2'd0,
      ST_CFG_SAMPLE = 2'd1,
      ST_RUN        = 2'd2
   } state_t;

   // Who owns the SRAM pins in the current clk24 cycle.
   typedef enum logic [1:0] {
      SLOT_CFG  = 2'd0,
      SLOT_SAM  = 2'd1,
      SLOT_HOST = 2'd2
   } slot_t;

endpackage

// File: rtl/sram_arbiter.sv
// Time-multiplexes one asynchronous SRAM between the machine (every phase-0
// cycle) and a 4-phase host port (phase-1 cycles), after reading a config byte.
module sram_arbiter
   import sram_arbiter_pkg::*;
#(
   parameter logic [20:0] CFG_ADDR = CFG_ADDR_DEF,
   parameter int          CFG_WAIT = CFG_WAIT_DEF
) (
   input  logic        clk24,
   input  logic        master_reset_n,
   input  logic [18:0] sam_addr,
   input  logic        sam_we_n,
   input  logic [7:0]  sam_dout,
   output logic [7:0]  sam_din,
   input  logic        host_req,
   input  logic        host_we,
   input  logic [20:0] host_addr,
   input  logic [7:0]  host_wdata,
   output logic        host_ack,
   output logic [7:0]  host_rdata,
   output logic [20:0] sram_addr,
   output logic        sram_we_n,
   output logic [7:0]  sram_data_o,
   output logic        sram_data_oe,
   input  logic [7:0]  sram_data_i,
   output logic [1:0]  cfg_data,
   output logic        cfg_valid
);

   localparam int CW = $clog2(CFG_WAIT + 2);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          phase_q, phase_d;
   logic          pend_q, pend_d;
   logic          ack_q, ack_d;
   logic          cfg_valid_q, cfg_valid_d;
   logic [1:0]    cfg_q, cfg_d;
   logic [7:0]    sam_din_q, sam_din_d;
   logic [7:0]    host_rdata_q, host_rdata_d;
   slot_t         slot;

   // Phase 1 goes to the host only when a transaction is already pending.
   assign slot = (state_q != ST_RUN)     ? SLOT_CFG  :
                 (phase_q && pend_q)     ? SLOT_HOST : SLOT_SAM;

   always_ff @(posedge clk24) begin
      if (!master_reset_n) begin
         state_q      <= ST_CFG_WAIT;
         cnt_q        <= '0;
         phase_q      <= 1'b0;
         pend_q       <= 1'b0;
         ack_q        <= 1'b0;
         cfg_valid_q  <= 1'b0;
         cfg_q        <= 2'b00;
         sam_din_q    <= 8'h00;
         host_rdata_q <= 8'h00;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         phase_q      <= phase_d;
         pend_q       <= pend_d;
         ack_q        <= ack_d;
         cfg_valid_q  <= cfg_valid_d;
         cfg_q        <= cfg_d;
         sam_din_q    <= sam_din_d;
         host_rdata_q <= host_rdata_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      phase_d      = phase_q;
      pend_d       = pend_q;
      ack_d        = ack_q;
      cfg_valid_d  = cfg_valid_q;
      cfg_d        = cfg_q;
      sam_din_d    = sam_din_q;
      host_rdata_d = host_rdata_q;
      case (state_q)
         ST_CFG_WAIT: begin
            if (cnt_q == CW'(CFG_WAIT)) state_d = ST_CFG_SAMPLE;
            else                        cnt_d   = cnt_q + 1'b1;
         end
         ST_CFG_SAMPLE: begin
            cfg_d       = sram_data_i[1:0];
            cfg_valid_d = 1'b1;
            phase_d     = 1'b0;
            state_d     = ST_RUN;
         end
         ST_RUN: begin
            phase_d = ~phase_q;
            if (slot == SLOT_HOST) begin
               pend_d = 1'b0;
               ack_d  = 1'b1;
               if (!host_we) host_rdata_d = sram_data_i;
            end else if (sam_we_n) begin
               sam_din_d = sram_data_i;
            end
            // 4-phase handshake: ack drops once req is seen low, and nothing
            // new is accepted until both ack and pending are clear.
            if (ack_q && !host_req)                  ack_d  = 1'b0;
            else if (!ack_q && !pend_q && host_req)  pend_d = 1'b1;
         end
         default: state_d = ST_CFG_WAIT;
      endcase
   end

   always_comb begin
      sram_addr    = CFG_ADDR;
      sram_we_n    = 1'b1;
      sram_data_oe = 1'b0;
      sram_data_o  = 8'h00;
      case (slot)
         SLOT_SAM: begin
            sram_addr    = {2'b00, sam_addr};
            sram_we_n    = sam_we_n;
            sram_data_oe = ~sam_we_n;
            sram_data_o  = sam_dout;
         end
         SLOT_HOST: begin
            sram_addr    = host_addr;
            sram_we_n    = ~host_we;
            sram_data_oe = host_we;
            sram_data_o  = host_wdata;
         end
         default: ;
      endcase
   end

   assign sam_din    = sam_din_q;
   assign host_ack   = ack_q;
   assign host_rdata = host_rdata_q;
   assign cfg_data   = cfg_q;
   assign cfg_valid  = cfg_valid_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized bench for sram_arbiter: a cycle-count reference model of the slot
// schedule and host handshake, plus directed checks of the boundary cases.
module tb_sram_arbiter;

   localparam logic [20:0] CFG_ADDR = 21'h008FD5;
   localparam int          CFG_WAIT = 7;

   logic        clk24 = 1'b0;
   logic        master_reset_n;
   logic [18:0] sam_addr;
   logic        sam_we_n;
   logic [7:0]  sam_dout;
   logic [7:0]  sam_din;
   logic        host_req;
   logic        host_we;
   logic [20:0] host_addr;
   logic [7:0]  host_wdata;
   logic        host_ack;
   logic [7:0]  host_rdata;
   logic [20:0] sram_addr;
   logic        sram_we_n;
   logic [7:0]  sram_data_o;
   logic        sram_data_oe;
   logic [7:0]  sram_data_i;
   logic [1:0]  cfg_data;
   logic        cfg_valid;

   sram_arbiter #(.CFG_ADDR(CFG_ADDR), .CFG_WAIT(CFG_WAIT)) dut (
      .clk24(clk24), .master_reset_n(master_reset_n),
      .sam_addr(sam_addr), .sam_we_n(sam_we_n), .sam_dout(sam_dout), .sam_din(sam_din),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
      .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
      .sram_addr(sram_addr), .sram_we_n(sram_we_n), .sram_data_o(sram_data_o),
      .sram_data_oe(sram_data_oe), .sram_data_i(sram_data_i),
      .cfg_data(cfg_data), .cfg_valid(cfg_valid)
   );

   always #5 clk24 = ~clk24;

   int checks = 0;
   int errors = 0;

   // Reference model: edges since reset release, cycles since entering RUN
   // (-1 before), and the visible host/SAM/config results.
   int         m_edge, m_run;
   logic       m_pend, m_ack, m_valid;
   logic [1:0] m_cfg;
   logic [7:0] m_hrd, m_sdin;
   bit         rnd;
   int         we0_cnt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_edge = 0; m_run = -1; m_pend = 0; m_ack = 0; m_valid = 0;
      m_cfg = 2'b00; m_hrd = 8'h00; m_sdin = 8'h00;
   endtask

   // Compare all outputs against the model, then advance model and DUT one edge.
   task automatic step();
      bit         host_slot;
      logic [20:0] e_addr;
      logic        e_we_n, e_oe;
      logic [7:0]  e_do;
      logic        n_ack, n_pend;
      if (rnd) begin
         sram_data_i = 8'($urandom);
         sam_addr    = 19'($urandom);
         sam_we_n    = 1'($urandom);
         sam_dout    = 8'($urandom);
      end
      #1;
      host_slot = (m_run >= 0) && (m_run % 2 == 1) && m_pend;
      if (m_run < 0) begin
         e_addr = CFG_ADDR; e_we_n = 1'b1; e_oe = 1'b0; e_do = 8'h00;
      end else if (host_slot) begin
         e_addr = host_addr; e_we_n = ~host_we; e_oe = host_we; e_do = host_wdata;
      end else begin
         e_addr = {2'b00, sam_addr}; e_we_n = sam_we_n; e_oe = ~sam_we_n; e_do = sam_dout;
      end
      check("cfg_valid", cfg_valid, m_valid);
      check("cfg_data", cfg_data, m_cfg);
      check("host_ack", host_ack, m_ack);
      check("host_rdata", host_rdata, m_hrd);
      check("sam_din", sam_din, m_sdin);
      check("sram_addr", sram_addr, e_addr);
      check("sram_we_n", sram_we_n, e_we_n);
      check("sram_data_oe", sram_data_oe, e_oe);
      if (e_oe) check("sram_data_o", sram_data_o, e_do);
      if (sram_we_n === 1'b0) we0_cnt++;

      if (!master_reset_n) begin
         model_reset();
      end else begin
         m_edge++;
         if (m_run >= 0) begin
            if (host_slot && !host_we) m_hrd = sram_data_i;
            if (!host_slot && sam_we_n) m_sdin = sram_data_i;
            n_ack = m_ack; n_pend = m_pend;
            if (host_slot) begin n_pend = 1'b0; n_ack = 1'b1; end
            if (m_ack && !host_req) n_ack = 1'b0;
            if (!m_ack && !m_pend && host_req) n_pend = 1'b1;
            m_ack = n_ack; m_pend = n_pend;
            m_run++;
         end else if (m_edge == CFG_WAIT + 2) begin
            m_cfg = sram_data_i[1:0]; m_valid = 1'b1; m_run = 0;
         end
      end
      @(posedge clk24);
      #1;
   endtask

   task automatic host_txn(input logic we, input logic [20:0] addr,
                           input logic [7:0] wdata, input int hold);
      int n;
      host_we = we; host_addr = addr; host_wdata = wdata; host_req = 1'b1;
      n = 0;
      while (host_ack !== 1'b1 && n < 12) begin step(); n++; end
      check("ack_seen", host_ack, 1'b1);
      for (int i = 0; i < hold; i++) begin
         step();
         check("ack_held", host_ack, 1'b1);
      end
      host_req = 1'b0;
      n = 0;
      while (host_ack !== 1'b0 && n < 4) begin step(); n++; end
      check("ack_drop", host_ack, 1'b0);
      host_addr = 21'($urandom); host_wdata = 8'($urandom); host_we = 1'($urandom);
   endtask

   initial begin
      rnd = 0; we0_cnt = 0;
      master_reset_n = 1'b0;
      sam_addr = '0; sam_we_n = 1'b1; sam_dout = '0;
      host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
      sram_data_i = 8'h02;
      @(posedge clk24); #1;
      model_reset();
      repeat (2) step();

      // Config read after release, address and we_n held throughout.
      master_reset_n = 1'b1;
      for (int i = 0; i < CFG_WAIT + 2; i++) begin
         check("cfg_addr_hold", sram_addr, CFG_ADDR);
         check("cfg_we_hold", sram_we_n, 1'b1);
         check("cfg_valid_early", cfg_valid, 1'b0);
         step();
      end
      check("cfg_valid_on", cfg_valid, 1'b1);
      check("cfg_data_10", cfg_data, 2'b10);

      // Plain SAM reads at a fixed address.
      sam_addr = 19'h12345; sam_we_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         sram_data_i = 8'($urandom);
         step();
         check("sam_rd_addr", sram_addr, 21'h012345);
      end

      // Host write aligned so req is seen at a phase-0 edge.
      while (m_run % 2 != 0) step();
      we0_cnt = 0;
      host_we = 1'b1; host_addr = 21'h1FFFFF; host_wdata = 8'hA5; host_req = 1'b1;
      step();
      check("wr_ack_1cyc", host_ack, 1'b0);
      step();
      check("wr_ack_2cyc", host_ack, 1'b1);
      host_txn(1'b1, 21'h1FFFFF, 8'hA5, 3);
      check("wr_one_slot", we0_cnt, 1);

      // Host read returning 8'h3C.
      sram_data_i = 8'h3C;
      host_we = 1'b0; host_addr = 21'h000100; host_req = 1'b1;
      while (host_ack !== 1'b1 && m_run < 1000) step();
      check("rd_rdata", host_rdata, 8'h3C);
      host_txn(1'b0, 21'h000100, 8'h00, 0);

      // Req held long after ack: no second slot until it drops.
      we0_cnt = 0;
      host_txn(1'b1, 21'h0ABCDE, 8'h5A, 6);
      check("hold_one_slot", we0_cnt, 1);

      // Randomized traffic on both ports.
      rnd = 1;
      for (int t = 0; t < 24; t++) begin
         repeat ($urandom_range(0, 3)) step();
         host_txn(1'($urandom), 21'($urandom), 8'($urandom), $urandom_range(0, 3));
      end
      rnd = 0;

      // Reset during a pending host write.
      sam_we_n = 1'b1;
      while (m_run % 2 != 1) step();
      host_we = 1'b1; host_addr = 21'h000777; host_wdata = 8'h11; host_req = 1'b1;
      step();
      master_reset_n = 1'b0;
      step();
      check("rst_ack", host_ack, 1'b0);
      check("rst_we_n", sram_we_n, 1'b1);
      check("rst_valid", cfg_valid, 1'b0);
      master_reset_n = 1'b1; host_req = 1'b0; sram_data_i = 8'h01;
      repeat (CFG_WAIT + 2) step();
      check("reread_valid", cfg_valid, 1'b1);
      check("reread_data", cfg_data, 2'b01);
      check("rst_no_ack", host_ack, 1'b0);
      repeat (4) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
